// File: rtl/ks_pluck_engine.sv
// ks_pluck_engine -- Karplus-Strong string engine driving a ks_regfile delay line.
//
// A pluck fills the delay line with 16-bit Galois LFSR noise (one word per
// cycle). After that, each sample tick reads the two adjacent taps at ptr-1
// and ptr, writes their (optionally decayed) average back at ptr, and emits
// the old value at ptr as the next audio sample.
//
// Optional feature macro: KS_DECAY_EN
//   defined   : written value = avg - (avg >>> DECAY_SHIFT), so the string dies out
//   undefined : written value = plain floor average of the two taps
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   pluck             one-cycle strike request (restarts the fill from any state)
//   tick              one-cycle sample-rate strobe
//   rs_write          regfile write enable
//   rs_addr           regfile address
//   rs_sample_in      regfile write data
//   rs_out1, rs_out2  regfile taps at rs_addr-1 (wrapping) and rs_addr
//   sample_out        signed audio sample, held between updates
//   sample_valid      one-cycle pulse when sample_out updates
//   busy              high while the delay line is being filled
//   overrun           sticky: a tick arrived while an update or fill was running

module ks_pluck_engine #(
    parameter int LEN         = 218,
    parameter int DECAY_SHIFT = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pluck,
    input  logic        tick,
    output logic        rs_write,
    output logic [7:0]  rs_addr,
    output logic [15:0] rs_sample_in,
    input  logic [15:0] rs_out1,
    input  logic [15:0] rs_out2,
    output logic [15:0] sample_out,
    output logic        sample_valid,
    output logic        busy,
    output logic        overrun
);

    if (LEN < 2 || LEN > 256 || DECAY_SHIFT < 0 || DECAY_SHIFT > 15) begin : g_bad_cfg
        $error("ks_pluck_engine: LEN must be 2..256 and DECAY_SHIFT 0..15");
    end

    localparam logic [7:0]  LAST      = 8'(LEN - 1);
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // x^16+x^14+x^13+x^11+1 in right-shifting Galois form
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_WAIT, S_READ, S_WRITE} state_t;

    state_t      state;
    logic [15:0] lfsr;
    logic [15:0] lfsr_nx;
    logic [7:0]  ptr;
    logic [7:0]  ptr_nx;
    logic [15:0] cur_q;
    logic [16:0] tap_sum;
    logic [15:0] avg;
    logic [15:0] avg_calc;

    assign lfsr_nx = lfsr[0] ? ((lfsr >> 1) ^ LFSR_MASK) : (lfsr >> 1);
    assign ptr_nx  = (ptr == LAST) ? 8'd0 : ptr + 8'd1;

    // 17-bit signed sum; bits [16:1] are the floor-halved average.
    assign tap_sum = {rs_out1[15], rs_out1} + {rs_out2[15], rs_out2};
    assign avg     = tap_sum[16:1];

`ifdef KS_DECAY_EN
    assign avg_calc = avg - 16'($signed(avg) >>> DECAY_SHIFT);
`else
    assign avg_calc = avg;
`endif

    // rs_addr doubles as the fill counter during FILL; rs_sample_in holds the
    // averaged value captured in READ for the WRITE cycle. lfsr always holds
    // the next noise word to be written.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            rs_write     <= 1'b0;
            rs_addr      <= 8'd0;
            rs_sample_in <= 16'd0;
            sample_out   <= 16'd0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
            ptr          <= 8'd0;
            cur_q        <= 16'd0;
            lfsr         <= LFSR_SEED;
        end else begin
            sample_valid <= 1'b0;
            // A tick coinciding with a pluck is discarded silently.
            if (tick && !pluck &&
                (state == S_FILL || state == S_READ || state == S_WRITE))
                overrun <= 1'b1;

            if (pluck) begin
                state        <= S_FILL;
                rs_write     <= 1'b1;
                rs_addr      <= 8'd0;
                rs_sample_in <= lfsr;
                lfsr         <= lfsr_nx;
                busy         <= 1'b1;
            end else begin
                case (state)
                    S_FILL: begin
                        if (rs_addr == LAST) begin
                            state        <= S_WAIT;
                            rs_write     <= 1'b0;
                            rs_addr      <= 8'd0;
                            rs_sample_in <= 16'd0;
                            ptr          <= 8'd0;
                            busy         <= 1'b0;
                        end else begin
                            rs_addr      <= rs_addr + 8'd1;
                            rs_sample_in <= lfsr;
                            lfsr         <= lfsr_nx;
                        end
                    end
                    S_WAIT: begin
                        if (tick)
                            state <= S_READ;
                    end
                    S_READ: begin
                        cur_q        <= rs_out2;
                        rs_sample_in <= avg_calc;
                        rs_write     <= 1'b1;
                        state        <= S_WRITE;
                    end
                    S_WRITE: begin
                        sample_out   <= cur_q;
                        sample_valid <= 1'b1;
                        ptr          <= ptr_nx;
                        rs_addr      <= ptr_nx;
                        rs_write     <= 1'b0;
                        rs_sample_in <= 16'd0;
                        state        <= S_WAIT;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ks_pluck_engine.sv
// Self-checking bench for ks_pluck_engine with a behavioural delay-line
// regfile and a sample-level reference model of the string.
module tb_ks_pluck_engine;

    localparam int LEN         = 218;
    localparam int DECAY_SHIFT = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        pluck, tick;
    logic        rs_write;
    logic [7:0]  rs_addr;
    logic [15:0] rs_sample_in, rs_out1, rs_out2, sample_out;
    logic        sample_valid, busy, overrun;

    ks_pluck_engine #(.LEN(LEN), .DECAY_SHIFT(DECAY_SHIFT)) dut (
        .clk(clk), .reset_n(reset_n), .pluck(pluck), .tick(tick),
        .rs_write(rs_write), .rs_addr(rs_addr), .rs_sample_in(rs_sample_in),
        .rs_out1(rs_out1), .rs_out2(rs_out2), .sample_out(sample_out),
        .sample_valid(sample_valid), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Delay-line regfile: combinational taps, write on the clock. The bench
    // can preload it through its own port while the engine sits in WAIT.
    logic [15:0] mem [0:LEN-1];
    logic        tb_wr = 1'b0;
    int          tb_wa = 0;
    logic [15:0] tb_wd = 16'd0;

    always_comb begin
        rs_out2 = mem[int'(rs_addr)];
        rs_out1 = (rs_addr == 8'd0) ? mem[LEN-1] : mem[int'(rs_addr) - 1];
    end

    always @(posedge clk) begin
        if (tb_wr) mem[tb_wa] <= tb_wd;
        else if (rs_write) mem[int'(rs_addr)] <= rs_sample_in;
    end

    // Reference model
    logic [15:0] ref_mem [0:LEN-1];
    logic [15:0] m_lfsr = 16'hACE1;
    int          m_ptr  = 0;
    logic        m_ovr  = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One step of x^16+x^14+x^13+x^11+1: shift right, fold the dropped bit
    // back into the tap positions 15,13,12,10.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic [15:0] r;
        r = v >> 1;
        if (v[0]) begin
            r[15] = ~r[15]; r[13] = ~r[13]; r[12] = ~r[12]; r[10] = ~r[10];
        end
        return r;
    endfunction

    function automatic int fdiv(input int n, input int d);
        if (n >= 0) return n / d;
        return -((-n + d - 1) / d);
    endfunction

    function automatic logic [15:0] m_avg(input logic [15:0] a, input logic [15:0] b);
        int s, v;
        s = int'($signed(a)) + int'($signed(b));
        v = fdiv(s, 2);
`ifdef KS_DECAY_EN
        v = v - fdiv(v, 1 << DECAY_SHIFT);
`endif
        return 16'(v);
    endfunction

    // All tasks start and end right after a falling edge.
    task automatic poke(input int a, input logic [15:0] d);
        tb_wr = 1'b1; tb_wa = a; tb_wd = d; ref_mem[a] = d;
        @(negedge clk);
        tb_wr = 1'b0;
    endtask

    task automatic do_fill(input bit with_tick);
        pluck = 1'b1; tick = with_tick;
        @(negedge clk);
        pluck = 1'b0; tick = 1'b0;
        for (int i = 0; i < LEN; i++) begin
            chk("fill_we", rs_write, 1);
            chk("fill_addr", rs_addr, i);
            chk("fill_data", rs_sample_in, m_lfsr);
            chk("fill_busy", busy, 1);
            ref_mem[i] = m_lfsr;
            m_lfsr = lfsr_step(m_lfsr);
            @(negedge clk);
        end
        chk("fill_end_busy", busy, 0);
        chk("fill_end_we", rs_write, 0);
        chk("fill_end_addr", rs_addr, 0);
        chk("fill_end_ovr", overrun, m_ovr);
        m_ptr = 0;
    endtask

    task automatic do_tick();
        logic [15:0] exp_w, exp_s;
        int prev;
        prev  = (m_ptr == 0) ? LEN - 1 : m_ptr - 1;
        exp_w = m_avg(ref_mem[prev], ref_mem[m_ptr]);
        exp_s = ref_mem[m_ptr];
        tick = 1'b1;
        chk("wait_we", rs_write, 0);
        @(negedge clk);
        tick = 1'b0;
        chk("read_we", rs_write, 0);
        chk("read_addr", rs_addr, m_ptr);
        @(negedge clk);
        chk("wr_we", rs_write, 1);
        chk("wr_addr", rs_addr, m_ptr);
        chk("wr_data", rs_sample_in, exp_w);
        chk("wr_sv", sample_valid, 0);
        @(negedge clk);
        chk("sv", sample_valid, 1);
        chk("sample", sample_out, exp_s);
        chk("post_we", rs_write, 0);
        ref_mem[m_ptr] = exp_w;
        m_ptr = (m_ptr + 1) % LEN;
    endtask

    task automatic mem_cmp(input string tag);
        int bad = 0;
        for (int i = 0; i < LEN; i++)
            if (mem[i] !== ref_mem[i]) bad++;
        chk(tag, bad, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int nw, nv;
        logic [15:0] exp_w, exp_s;

        reset_n = 1'b0; pluck = 1'b0; tick = 1'b0;
        for (int i = 0; i < LEN; i++) begin
            mem[i] = 16'd0; ref_mem[i] = 16'd0;
        end
        repeat (3) @(negedge clk);
        chk("rst_we", rs_write, 0);
        chk("rst_addr", rs_addr, 0);
        chk("rst_din", rs_sample_in, 0);
        chk("rst_sout", sample_out, 0);
        chk("rst_sv", sample_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", overrun, 0);
        reset_n = 1'b1;

        nw = 0; nv = 0;
        repeat (20) begin
            @(negedge clk);
            nw += int'(rs_write); nv += int'(sample_valid);
        end
        chk("idle_writes", nw, 0);
        chk("idle_valids", nv, 0);

        // First pluck: seed word first, 218 writes
        do_fill(1'b0);

        // Directed averages
        poke(LEN - 1, 16'h0010);
        poke(0, 16'h0030);
        do_tick();
        chk("dir_avg_pos", mem[0], 16'h0020);
        chk("dir_sample", sample_out, 16'h0030);
        poke(0, 16'hFFFF);
        poke(1, 16'h0000);
        do_tick();
        chk("dir_avg_neg", mem[1], 16'hFFFF);

        // Random delay-line contents, enough ticks to wrap the pointer
        for (int i = 0; i < LEN; i++) poke(i, 16'($urandom));
        for (int k = 0; k < LEN + 2; k++) begin
            do_tick();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        mem_cmp("mem_after_wrap");

        // Pluck and tick together in WAIT: fill restarts, no overrun,
        // noise continues from where the LFSR left off.
        do_fill(1'b1);
        chk("pluck_tick_ovr", overrun, 0);

        // Tick during READ: overrun, single update
        exp_w = m_avg(ref_mem[LEN - 1], ref_mem[0]);
        exp_s = ref_mem[0];
        nw = 0; nv = 0;
        tick = 1'b1;
        @(negedge clk);
        nw += int'(rs_write); nv += int'(sample_valid);
        @(negedge clk);
        tick = 1'b0;
        repeat (6) begin
            nw += int'(rs_write); nv += int'(sample_valid);
            @(negedge clk);
        end
        m_ovr = 1'b1;
        chk("ovr_flag", overrun, m_ovr);
        chk("ovr_writes", nw, 1);
        chk("ovr_valids", nv, 1);
        chk("ovr_sample", sample_out, exp_s);
        ref_mem[0] = exp_w;
        m_ptr = 1;
        mem_cmp("mem_after_ovr");
        do_tick();
        chk("ovr_sticky", overrun, 1);

        // Reset in the middle of a fill
        pluck = 1'b1;
        @(negedge clk);
        pluck = 1'b0;
        repeat (10) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_we", rs_write, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ovr", overrun, 0);
        chk("midrst_addr", rs_addr, 0);
        @(negedge clk);
        reset_n = 1'b1;
        m_lfsr = 16'hACE1; m_ovr = 1'b0;
        @(negedge clk);
        chk("postrst_we", rs_write, 0);
        chk("postrst_busy", busy, 0);

        // LFSR back at its seed after reset
        do_fill(1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
